// File: rtl/hex_scan_display.sv
// Multiplexed hex display scanner: time-slots DIGITS active-low digits from load-captured shadow registers.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_scan_display #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  scan_tick
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_val;
  logic [DIGITS-1:0]   r_dpm;
  logic [DIGITS-1:0]   r_en;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_tick;

  logic                w_wrap;
  logic [3:0]          w_nib;
  logic                w_show;
  logic                w_lit;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] w_lz;
  logic              w_zero_above;

  // w_lz[i] is set when nibbles i..DIGITS-1 are all zero; digit 0 is never suppressed.
  always_comb begin
    w_lz         = '0;
    w_zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_val[4*i +: 4] == 4'h0);
      w_lz[i]      = w_zero_above;
    end
  end

  always_comb w_show = r_en[r_idx] & ~w_lz[r_idx];
`else
  always_comb w_show = r_en[r_idx];
`endif

  always_comb begin
    w_wrap = (r_cnt == CW'(REFRESH_DIV - 1));
    w_nib  = r_val[4*r_idx +: 4];
    w_lit  = w_show & (r_cnt >= CW'(GUARD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_val  <= '0;
      r_dpm  <= '0;
      r_en   <= '0;
      r_seg  <= '1;
      r_dp   <= 1'b1;
      r_an   <= '1;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
      if (w_wrap)
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_val <= value;
        r_dpm <= dp_in;
        r_en  <= digit_en;
      end
      // Outputs are computed from pre-edge index/counter/shadow state.
      r_an  <= w_lit ? ~(DIGITS'(1) << r_idx) : '1;
      r_seg <= w_lit ? ~glyph(w_nib) : '1;
      r_dp  <= ~(w_lit & r_dpm[r_idx]);
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign scan_tick = r_tick;

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of multiplexed hex digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (>= 4).
REQ-003 SHALL have parameter GUARD, default 2, giving blanked cycles at the start of each slot to suppress ghosting (< REFRESH_DIV).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port value, input, 4*DIGITS, the hex nibbles; nibble i at bits [4i+3:4i] drives digit i (digit 0 rightmost).
REQ-007 SHALL have port dp_in, input, DIGITS, the decimal-point request per digit (1 = lit).
REQ-008 SHALL have port digit_en, input, DIGITS, the per-digit enable (0 = digit blanked).
REQ-009 SHALL have port load, input, 1, a strobe that captures value, dp_in and digit_en into shadow registers.
REQ-010 SHALL have port seg, output, 7, active-low segments; seg[0]=a ... seg[6]=g.
REQ-011 SHALL have port dp, output, 1, the active-low decimal point.
REQ-012 SHALL have port an, output, DIGITS, active-low one-cold anode select.
REQ-013 SHALL have port scan_tick, output, 1, a one-cycle pulse on every digit-index advance.

Function
REQ-014 SHALL hold a slot counter 0..REFRESH_DIV-1 that increments every cycle and wraps to 0.
REQ-015 SHALL advance the digit index by 1 when the slot counter wraps, with DIGITS-1 wrapping to 0, and pulse scan_tick in that same cycle.
REQ-016 SHALL capture value/dp_in/digit_en into the shadow registers on the clock edge where load=1; otherwise the shadows hold.
REQ-017 SHALL drive display outputs only from the shadow registers, never directly from value/dp_in/digit_en.
REQ-018 SHALL register seg, dp and an; each output reflects the index, counter and shadow state of the previous cycle (1-cycle latency).
REQ-019 SHALL drive an all ones, seg 7'h7F and dp 1 while the slot counter is < GUARD.
REQ-020 SHALL, outside the guard window, drive an with only bit [index] low and seg with the standard hex glyph of shadow nibble [index] (0-9, A, b, C, d, E, F).
REQ-021 SHALL drive dp low only when shadow dp_in[index]=1 and the digit is displayed.
REQ-022 SHALL, when shadow digit_en[index]=0, keep an all ones, seg 7'h7F and dp 1 for the whole slot while the index still advances normally.
REQ-023 SHALL apply a load that coincides with a slot wrap to the new digit's first displayed cycle; the guard window ensures no glitch.
REQ-024 SHALL use the following glyph encodings (a..g, 1=lit, shown as seg inverted): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.

Reset
REQ-025 SHALL, on a clock edge with rst_n=0, set slot counter 0, index 0, all shadows 0, an all ones, seg 7'h7F, dp 1 and scan_tick 0.
REQ-026 SHALL let reset override load and the counter wrap in the same cycle, and an assertion mid-slot aborts the slot immediately.
REQ-027 SHALL begin the first slot (index 0, guard window first) on the first edge after rst_n returns to 1.

Configuration
REQ-028 SHALL, when macro HEX_SCAN_LEADING_ZERO_BLANK_EN is defined, blank digit i>0 (as with digit_en=0) if shadow nibbles i..DIGITS-1 are all zero; digit 0 is never suppressed.
REQ-029 SHALL, when HEX_SCAN_LEADING_ZERO_BLANK_EN is undefined, show all enabled digits including leading zeros, with no suppression logic synthesised.

Verification (DIGITS=4, REFRESH_DIV=4, GUARD=1)
REQ-030 SHALL cover reset: hold rst_n=0 for 3 cycles -> an=4'hF, seg=7'h7F, dp=1, scan_tick=0; release -> scan_tick pulses every 4 cycles.
REQ-031 SHALL cover the scan sequence: load value=16'h12AF, dp_in=4'b0100, digit_en=4'hF -> successive slots show an=E/seg=~71, an=D/seg=~77, an=B/seg=~5B with dp=0, an=7/seg=~06, then repeat.
REQ-032 SHALL cover the guard: the first cycle of each slot shows an=4'hF and seg=7'h7F.
REQ-033 SHALL cover shadowing: change value to 16'hFFFF without load -> display unchanged; pulse load -> new glyphs from the next output cycle.
REQ-034 SHALL cover enable: digit_en=4'b1010 -> slots for digits 0 and 2 keep an=4'hF for all 4 cycles.
REQ-035 SHALL cover the macro: with HEX_SCAN_LEADING_ZERO_BLANK_EN and value=16'h0005 -> only digit 0 lit showing ~6D; with value=16'h0000 -> digit 0 shows ~3F.
